// File: rtl/output_block.sv
// output_block: parallel-to-serial row streamer.
// Captures up to three LENGTH-byte coefficient rows on a single load strobe
// and streams the selected bytes out one per accepted valid/ready transfer.
//
// Ports:
//   clk        system clock, rising edge
//   reset      asynchronous, active-high reset
//   load       capture request, honoured only when idle
//   iter_flag  row-count select sampled with load:
//              0 = rows 0,1,2; 1 = rows 1,2; 2 = row 1; 3 = ignored
//   in_row_0/1/2  LENGTH bytes each, element i at bits [8*i+7:8*i]
//   out        current serial byte (meaningful only while out_valid=1)
//   out_valid  out holds a valid byte
//   out_ready  downstream accepts out on this edge when out_valid=1
//   busy       high while a transfer or its done cycle is in progress
//   done       one-cycle pulse after the last byte is accepted
module output_block #(
  parameter int unsigned LENGTH = 256
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                load,
  input  logic [1:0]          iter_flag,
  input  logic [8*LENGTH-1:0] in_row_0,
  input  logic [8*LENGTH-1:0] in_row_1,
  input  logic [8*LENGTH-1:0] in_row_2,
  output logic [7:0]          out,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                busy,
  output logic                done
);

  localparam int unsigned ROWW = 8 * LENGTH;
  localparam int unsigned BUFW = 3 * ROWW;

  // Index of the final byte for each row-count selection.
  localparam logic [9:0] LAST_3 = 10'(3 * LENGTH - 1);
  localparam logic [9:0] LAST_2 = 10'(2 * LENGTH - 1);
  localparam logic [9:0] LAST_1 = 10'(LENGTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SEND,
    ST_DONE
  } state_t;

  state_t          state;
  state_t          state_next;
  logic [9:0]      counter;
  logic [9:0]      last_idx;
  logic [1:0]      iter;
  logic [BUFW-1:0] buffer;
  logic [BUFW-1:0] shifted;
  logic            accept;
  logic            xfer;
  logic            final_xfer;

  always_comb begin
    accept     = 1'b0;
    xfer       = 1'b0;
    final_xfer = 1'b0;
    last_idx   = LAST_1;
    state_next = state;

    case (iter)
      2'd0:    last_idx = LAST_3;
      2'd1:    last_idx = LAST_2;
      default: last_idx = LAST_1;
    endcase

    accept     = (state == ST_IDLE) && load && (iter_flag != 2'd3);
    xfer       = (state == ST_SEND) && out_ready;
    final_xfer = xfer && (counter == last_idx);

    case (state)
      ST_IDLE: if (accept) state_next = ST_SEND;
      ST_SEND: if (final_xfer) state_next = ST_DONE;
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  // Byte that follows the current one; the shift keeps the select free of
  // array-index width constraints for any legal LENGTH.
  assign shifted = buffer >> {counter + 10'd1, 3'b000};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      counter <= '0;
      iter    <= '0;
      out     <= '0;
    end else if (accept) begin
      iter    <= iter_flag;
      counter <= '0;
      // The buffer is written on this same edge, so the first byte is taken
      // straight from the selected input row to get single-cycle latency.
      out     <= (iter_flag == 2'd0) ? in_row_0[7:0] : in_row_1[7:0];
    end else if (xfer && !final_xfer) begin
      counter <= counter + 10'd1;
      out     <= shifted[7:0];
    end
  end

  // Row buffer needs no reset: it is always written before being read.
  always_ff @(posedge clk) begin
    if (accept) begin
      buffer[ROWW-1:0]        <= (iter_flag == 2'd0) ? in_row_0 : in_row_1;
      buffer[2*ROWW-1:ROWW]   <= (iter_flag == 2'd0) ? in_row_1 : in_row_2;
      buffer[3*ROWW-1:2*ROWW] <= in_row_2;
    end
  end

  assign out_valid = (state == ST_SEND);
  assign busy      = (state != ST_IDLE);
  assign done      = (state == ST_DONE);

endmodule

// File: tb/tb_output_block.sv
// Self-checking bench for output_block with LENGTH=4.
module tb_output_block;
  localparam int unsigned L = 4;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         load = 1'b0;
  logic [1:0]   iter_flag = '0;
  logic [8*L-1:0] r0 = '0;
  logic [8*L-1:0] r1 = '0;
  logic [8*L-1:0] r2 = '0;
  logic [7:0]   out;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic         busy;
  logic         done;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] exp_q[$];
  logic [7:0] rx_q[$];
  int         done_at;
  int         stab_err;

  always #5 clk = ~clk;

  output_block #(.LENGTH(L)) dut (
    .clk       (clk),
    .reset     (reset),
    .load      (load),
    .iter_flag (iter_flag),
    .in_row_0  (r0),
    .in_row_1  (r1),
    .in_row_2  (r2),
    .out       (out),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy),
    .done      (done)
  );

  // Row whose element i holds b0+i.
  function automatic logic [8*L-1:0] make_row(input int b0);
    logic [8*L-1:0] r;
    r = '0;
    for (int i = 0; i < int'(L); i++)
      r = r | ((8*L)'(8'(b0 + i)) << (8 * i));
    return r;
  endfunction

  function automatic void push_row(input logic [8*L-1:0] r);
    for (int i = 0; i < int'(L); i++)
      exp_q.push_back(8'(r >> (8 * i)));
  endfunction

  function automatic logic ready_pat(input int cyc);
    int k;
    k = (cyc - 1) % 6;
    return (k == 0) || (k == 3) || (k == 5);
  endfunction

  // Enter and leave at a negedge; the scoreboard gets the bytes the
  // row mapping says should be streamed.
  task automatic do_load(input logic [1:0] it, input logic [8*L-1:0] a,
                         input logic [8*L-1:0] b, input logic [8*L-1:0] c);
    iter_flag = it;
    r0 = a;
    r1 = b;
    r2 = c;
    load = 1'b1;
    if (it == 2'd0) begin
      push_row(a); push_row(b); push_row(c);
    end else if (it == 2'd1) begin
      push_row(b); push_row(c);
    end else if (it == 2'd2) begin
      push_row(b);
    end
    @(negedge clk);
    load = 1'b0;
  endtask

  // Collects accepted bytes, notes the cycle done is seen and counts
  // stalled cycles where out/out_valid moved. Leaves at the done negedge.
  task automatic collect(input int mode, input int budget);
    logic       prev_stall;
    logic [7:0] prev_out;
    rx_q.delete();
    done_at    = 0;
    stab_err   = 0;
    prev_stall = 1'b0;
    prev_out   = '0;
    for (int cyc = 1; cyc <= budget; cyc++) begin
      out_ready = (mode == 0) ? 1'b1 : ready_pat(cyc);
      if (prev_stall && (out_valid !== 1'b1 || out !== prev_out)) stab_err++;
      if (done === 1'b1) begin
        done_at = cyc;
        break;
      end
      if (out_valid === 1'b1 && out_ready) rx_q.push_back(out);
      prev_stall = (out_valid === 1'b1) && !out_ready;
      prev_out   = out;
      @(negedge clk);
    end
    out_ready = 1'b1;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_checks++;
    if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done); end
    n_checks++;
    if (out !== 8'd0) begin n_fail++; $display("FAIL reset_out: got %0d want 0", out); end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_three_rows;
    do_load(2'd0, make_row(1), make_row(5), make_row(9));
    n_checks++;
    if (out_valid !== 1'b1 || out !== 8'd1) begin
      n_fail++; $display("FAIL three_latency: valid=%b out=%0d want valid=1 out=1", out_valid, out);
    end
    n_checks++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL three_busy: got %b want 1", busy); end
    collect(0, 40);
    n_checks++;
    if (done_at != 13) begin n_fail++; $display("FAIL three_done_cycle: got %0d want 13", done_at); end
    n_checks++;
    if (rx_q.size() != 12) begin n_fail++; $display("FAIL three_count: got %0d want 12", rx_q.size()); end
    while (rx_q.size() > 0 && exp_q.size() > 0) begin
      logic [7:0] g, e;
      g = rx_q.pop_front();
      e = exp_q.pop_front();
      n_checks++;
      if (g !== e) begin n_fail++; $display("FAIL three_byte: got %0d want %0d", g, e); end
    end
    exp_q.delete();
    @(negedge clk);
    n_checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL three_after_done: done=%b busy=%b want 0 0", done, busy);
    end
  endtask

  task automatic test_iter_select;
    for (int it = 1; it <= 2; it++) begin
      int n;
      n = (it == 1) ? 8 : 4;
      do_load(2'(it), make_row(1), make_row(5), make_row(9));
      collect(0, 40);
      n_checks++;
      if (done_at != n + 1) begin n_fail++; $display("FAIL iter%0d_done_cycle: got %0d want %0d", it, done_at, n + 1); end
      n_checks++;
      if (rx_q.size() != n) begin n_fail++; $display("FAIL iter%0d_count: got %0d want %0d", it, rx_q.size(), n); end
      while (rx_q.size() > 0 && exp_q.size() > 0) begin
        logic [7:0] g, e;
        g = rx_q.pop_front();
        e = exp_q.pop_front();
        n_checks++;
        if (g !== e) begin n_fail++; $display("FAIL iter%0d_byte: got %0d want %0d", it, g, e); end
      end
      exp_q.delete();
      @(negedge clk);
    end
  endtask

  task automatic test_backpressure;
    do_load(2'd0, make_row(1), make_row(5), make_row(9));
    collect(1, 100);
    n_checks++;
    if (done_at == 0) begin n_fail++; $display("FAIL bp_timeout: done not seen within 100 cycles, want done"); end
    n_checks++;
    if (stab_err != 0) begin n_fail++; $display("FAIL bp_stable: got %0d unstable stall cycles want 0", stab_err); end
    n_checks++;
    if (rx_q.size() != 12) begin n_fail++; $display("FAIL bp_count: got %0d want 12", rx_q.size()); end
    while (rx_q.size() > 0 && exp_q.size() > 0) begin
      logic [7:0] g, e;
      g = rx_q.pop_front();
      e = exp_q.pop_front();
      n_checks++;
      if (g !== e) begin n_fail++; $display("FAIL bp_byte: got %0d want %0d", g, e); end
    end
    exp_q.delete();
    @(negedge clk);
  endtask

  task automatic test_ignored_load;
    do_load(2'd0, make_row(1), make_row(5), make_row(9));
    fork
      collect(0, 40);
      begin
        repeat (3) @(negedge clk);
        r0 = make_row(100);
        r1 = make_row(110);
        r2 = make_row(120);
        iter_flag = 2'd2;
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
      end
    join
    n_checks++;
    if (done_at != 13) begin n_fail++; $display("FAIL ign_done_cycle: got %0d want 13", done_at); end
    n_checks++;
    if (rx_q.size() != 12) begin n_fail++; $display("FAIL ign_count: got %0d want 12", rx_q.size()); end
    while (rx_q.size() > 0 && exp_q.size() > 0) begin
      logic [7:0] g, e;
      g = rx_q.pop_front();
      e = exp_q.pop_front();
      n_checks++;
      if (g !== e) begin n_fail++; $display("FAIL ign_byte: got %0d want %0d", g, e); end
    end
    exp_q.delete();
    @(negedge clk);
    do_load(2'd3, make_row(1), make_row(5), make_row(9));
    n_checks++;
    if (busy !== 1'b0 || out_valid !== 1'b0) begin
      n_fail++; $display("FAIL iter3_ignored: busy=%b valid=%b want 0 0", busy, out_valid);
    end
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0 || out_valid !== 1'b0) begin
      n_fail++; $display("FAIL iter3_still_idle: busy=%b valid=%b want 0 0", busy, out_valid);
    end
  endtask

  task automatic test_reset_mid;
    do_load(2'd0, make_row(1), make_row(5), make_row(9));
    out_ready = 1'b1;
    repeat (5) @(negedge clk);
    n_checks++;
    if (out !== 8'd6 || out_valid !== 1'b1) begin
      n_fail++; $display("FAIL mid_before_reset: out=%0d valid=%b want 6 1", out, out_valid);
    end
    #2 reset = 1'b1;
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      n_fail++; $display("FAIL mid_async_reset: valid=%b busy=%b done=%b want 0 0 0", out_valid, busy, done);
    end
    @(negedge clk);
    reset = 1'b0;
    exp_q.delete();
    @(negedge clk);
    do_load(2'd0, make_row(21), make_row(25), make_row(29));
    collect(0, 40);
    n_checks++;
    if (done_at != 13) begin n_fail++; $display("FAIL mid_done_cycle: got %0d want 13", done_at); end
    n_checks++;
    if (rx_q.size() != 12) begin n_fail++; $display("FAIL mid_count: got %0d want 12", rx_q.size()); end
    while (rx_q.size() > 0 && exp_q.size() > 0) begin
      logic [7:0] g, e;
      g = rx_q.pop_front();
      e = exp_q.pop_front();
      n_checks++;
      if (g !== e) begin n_fail++; $display("FAIL mid_byte: got %0d want %0d", g, e); end
    end
    exp_q.delete();
    @(negedge clk);
  endtask

  task automatic test_back_to_back;
    do_load(2'd0, make_row(40), make_row(44), make_row(48));
    collect(0, 40);
    n_checks++;
    if (done_at != 13) begin n_fail++; $display("FAIL b2b_first_done: got %0d want 13", done_at); end
    while (rx_q.size() > 0 && exp_q.size() > 0) begin
      logic [7:0] g, e;
      g = rx_q.pop_front();
      e = exp_q.pop_front();
      n_checks++;
      if (g !== e) begin n_fail++; $display("FAIL b2b_first_byte: got %0d want %0d", g, e); end
    end
    exp_q.delete();
    // Load raised during the done cycle (ignored) and held into idle (taken).
    r0 = make_row(60);
    r1 = make_row(64);
    r2 = make_row(68);
    iter_flag = 2'd0;
    load = 1'b1;
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0 || out_valid !== 1'b0) begin
      n_fail++; $display("FAIL b2b_load_in_done: busy=%b valid=%b want 0 0", busy, out_valid);
    end
    push_row(r0); push_row(r1); push_row(r2);
    @(negedge clk);
    load = 1'b0;
    n_checks++;
    if (out_valid !== 1'b1 || out !== 8'd60) begin
      n_fail++; $display("FAIL b2b_latency: valid=%b out=%0d want 1 60", out_valid, out);
    end
    collect(0, 40);
    n_checks++;
    if (done_at != 13) begin n_fail++; $display("FAIL b2b_second_done: got %0d want 13", done_at); end
    n_checks++;
    if (rx_q.size() != 12) begin n_fail++; $display("FAIL b2b_count: got %0d want 12", rx_q.size()); end
    while (rx_q.size() > 0 && exp_q.size() > 0) begin
      logic [7:0] g, e;
      g = rx_q.pop_front();
      e = exp_q.pop_front();
      n_checks++;
      if (g !== e) begin n_fail++; $display("FAIL b2b_second_byte: got %0d want %0d", g, e); end
    end
    exp_q.delete();
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    @(negedge clk);
    test_reset();
    test_three_rows();
    test_iter_select();
    test_backpressure();
    test_ignored_load();
    test_reset_mid();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
